alu_share_arb: RTL and testbench

- Arbitrates one shared 32-bit ALU (alu_ov: a, b, aluc in; r, z, v out) between two requesters, e.g. the main pipeline EX stage and the multi-cycle mul/div/address helper.
- Each requester gets a valid/ready request channel and a private one-entry response buffer.
- Operands are registered before the ALU and results are registered after it, so the ALU sits between two flop stages.
- Selection is round-robin, or fixed priority when configured.

---
 rtl/alu_share_arb.sv | 157 +++++++++++++++
 tb/tb_alu_share_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-requester arbiter for one shared 32-bit ALU, registered on both sides.
// Each requester has a valid/ready request channel and a one-entry response buffer.
module alu_share_arb #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_aluc,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_r,
  output logic        rsp0_z,
  output logic        rsp0_v,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_aluc,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_r,
  output logic        rsp1_z,
  output logic        rsp1_v,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_z,
  input  logic        alu_v,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  logic [0:0]  state_r;
  logic        last_grant_r;
  logic        owner_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic [3:0]  op_aluc_r;
  logic        rsp0_valid_r;
  logic [31:0] rsp0_res_r;
  logic        rsp0_z_r;
  logic        rsp0_v_r;
  logic        rsp1_valid_r;
  logic [31:0] rsp1_res_r;
  logic        rsp1_z_r;
  logic        rsp1_v_r;
  logic        elig0_s;
  logic        elig1_s;
  logic        grant0_s;
  logic        grant1_s;

  // A requester still holding an unconsumed result cannot be granted.
  assign elig0_s = req0_valid & ~rsp0_valid_r;
  assign elig1_s = req1_valid & ~rsp1_valid_r;

  // Winner selection; last_grant_r=1 means requester 1 won last, so 0 wins the tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == ST_IDLE) && clrn) begin
      if (elig0_s && elig1_s) begin
        if ((PRIO_FIXED != 0) || last_grant_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        grant0_s = elig0_s;
        grant1_s = elig1_s;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Control FSM and operand register feeding the ALU.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      op_a_r       <= 32'h0000_0000;
      op_b_r       <= 32'h0000_0000;
      op_aluc_r    <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant0_s || grant1_s) begin
            op_a_r       <= grant1_s ? req1_a : req0_a;
            op_b_r       <= grant1_s ? req1_b : req0_b;
            op_aluc_r    <= grant1_s ? req1_aluc : req0_aluc;
            owner_r      <= grant1_s;
            last_grant_r <= grant1_s;
            state_r      <= ST_EXEC;
          end
        end
        ST_EXEC: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Response buffers: an EXEC fills only its owner's buffer; a handshake drains it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rsp0_valid_r <= 1'b0;
      rsp0_res_r   <= 32'h0000_0000;
      rsp0_z_r     <= 1'b0;
      rsp0_v_r     <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp1_res_r   <= 32'h0000_0000;
      rsp1_z_r     <= 1'b0;
      rsp1_v_r     <= 1'b0;
    end else begin
      if ((state_r == ST_EXEC) && !owner_r) begin
        rsp0_valid_r <= 1'b1;
        rsp0_res_r   <= alu_r;
        rsp0_z_r     <= alu_z;
        rsp0_v_r     <= alu_v;
      end else if (rsp0_ready && rsp0_valid_r) begin
        rsp0_valid_r <= 1'b0;
      end
      if ((state_r == ST_EXEC) && owner_r) begin
        rsp1_valid_r <= 1'b1;
        rsp1_res_r   <= alu_r;
        rsp1_z_r     <= alu_z;
        rsp1_v_r     <= alu_v;
      end else if (rsp1_ready && rsp1_valid_r) begin
        rsp1_valid_r <= 1'b0;
      end
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp0_r     = rsp0_res_r;
  assign rsp0_z     = rsp0_z_r;
  assign rsp0_v     = rsp0_v_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp1_r     = rsp1_res_r;
  assign rsp1_z     = rsp1_z_r;
  assign rsp1_v     = rsp1_v_r;
  assign alu_a      = op_a_r;
  assign alu_b      = op_b_r;
  assign alu_aluc   = op_aluc_r;
  assign busy       = (state_r == ST_EXEC);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a round-robin and a fixed-priority instance
// share the same request stimulus, each driving its own behavioural ALU.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = 32'h0, req0_b = 32'h0, req1_a = 32'h0, req1_b = 32'h0;
  logic [3:0]  req0_aluc = 4'h0, req1_aluc = 4'h0;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  logic        d_req0_ready, d_req1_ready, d_rsp0_valid, d_rsp1_valid;
  logic [31:0] d_rsp0_r, d_rsp1_r, d_alu_a, d_alu_b, d_alu_r;
  logic        d_rsp0_z, d_rsp0_v, d_rsp1_z, d_rsp1_v, d_alu_z, d_alu_v, d_busy;
  logic [3:0]  d_alu_aluc;

  logic        p_req0_ready, p_req1_ready, p_rsp0_valid, p_rsp1_valid;
  logic [31:0] p_rsp0_r, p_rsp1_r, p_alu_a, p_alu_b, p_alu_r;
  logic        p_rsp0_z, p_rsp0_v, p_rsp1_z, p_rsp1_v, p_alu_z, p_alu_v, p_busy;
  logic [3:0]  p_alu_aluc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] r;
    logic        v;
    r = 32'h0;
    v = 1'b0;
    case (c)
      4'b0000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0100: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0001: r = a & b;
      4'b0101: r = a | b;
      4'b0010: r = a ^ b;
      4'b0110: r = {b[15:0], 16'h0000};
      4'b0011: r = b << a[4:0];
      4'b0111: r = b >> a[4:0];
      4'b1111: r = $unsigned($signed(b) >>> a[4:0]);
      default: r = 32'h0;
    endcase
    return {r, (r == 32'h0), v};
  endfunction

  assign {d_alu_r, d_alu_z, d_alu_v} = alu_f(d_alu_a, d_alu_b, d_alu_aluc);
  assign {p_alu_r, p_alu_z, p_alu_v} = alu_f(p_alu_a, p_alu_b, p_alu_aluc);

  alu_share_arb #(.PRIO_FIXED(0)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_ready(d_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_aluc(req0_aluc), .rsp0_valid(d_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_r(d_rsp0_r), .rsp0_z(d_rsp0_z), .rsp0_v(d_rsp0_v),
    .req1_valid(req1_valid), .req1_ready(d_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_aluc(req1_aluc), .rsp1_valid(d_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_r(d_rsp1_r), .rsp1_z(d_rsp1_z), .rsp1_v(d_rsp1_v),
    .alu_a(d_alu_a), .alu_b(d_alu_b), .alu_aluc(d_alu_aluc),
    .alu_r(d_alu_r), .alu_z(d_alu_z), .alu_v(d_alu_v), .busy(d_busy)
  );

  alu_share_arb #(.PRIO_FIXED(1)) dut_p (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_ready(p_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_aluc(req0_aluc), .rsp0_valid(p_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_r(p_rsp0_r), .rsp0_z(p_rsp0_z), .rsp0_v(p_rsp0_v),
    .req1_valid(req1_valid), .req1_ready(p_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_aluc(req1_aluc), .rsp1_valid(p_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_r(p_rsp1_r), .rsp1_z(p_rsp1_z), .rsp1_v(p_rsp1_v),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_aluc(p_alu_aluc),
    .alu_r(p_alu_r), .alu_z(p_alu_z), .alu_v(p_alu_v), .busy(p_busy)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    n_cmp++; if (d_req0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", d_req0_ready); end
    n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", d_busy); end
    n_cmp++; if ({d_rsp0_valid, d_rsp1_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", {d_rsp0_valid, d_rsp1_valid}); end
    n_cmp++; if (d_alu_aluc !== 4'b0000) begin n_bad++; $display("FAIL rst_aluc: got %h want 0", d_alu_aluc); end
    n_cmp++; if (d_rsp0_r !== 32'h0) begin n_bad++; $display("FAIL rst_rsp0_r: got %h want 0", d_rsp0_r); end
    req0_valid = 1'b0;
    clrn = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001; req0_aluc = 4'b0000;
    #1;
    n_cmp++; if ({d_req0_ready, d_req1_ready} !== 2'b10) begin n_bad++; $display("FAIL add_ready: got %b want 10", {d_req0_ready, d_req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL add_busy: got %b want 1", d_busy); end
    n_cmp++; if (d_alu_a !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL add_alu_a: got %h want 7fffffff", d_alu_a); end
    n_cmp++; if (d_rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL add_early: got %b want 0", d_rsp0_valid); end
    @(negedge clk);
    n_cmp++; if (d_rsp0_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", d_rsp0_valid); end
    n_cmp++; if ({d_rsp0_r, d_rsp0_z, d_rsp0_v} !== {32'h8000_0000, 1'b0, 1'b1}) begin n_bad++; $display("FAIL add_result: got %h z%b v%b want 80000000 z0 v1", d_rsp0_r, d_rsp0_z, d_rsp0_v); end
    n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL add_busy_done: got %b want 0", d_busy); end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    n_cmp++; if (d_rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL add_consume: got %b want 0", d_rsp0_valid); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5; req1_aluc = 4'b0100;
    #1;
    n_cmp++; if (d_req1_ready !== 1'b1) begin n_bad++; $display("FAIL sub_ready: got %b want 1", d_req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({d_rsp1_valid, d_rsp1_r, d_rsp1_z, d_rsp1_v} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sub_result: got v%b %h z%b v%b want v1 0 z1 v0", d_rsp1_valid, d_rsp1_r, d_rsp1_z, d_rsp1_v); end
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_aluc = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (d_req1_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b want 0", i, d_req1_ready); end
      @(negedge clk);
      n_cmp++; if ({d_rsp1_valid, d_rsp1_r, d_rsp1_z} !== {1'b1, 32'h0, 1'b1}) begin n_bad++; $display("FAIL hold_rsp[%0d]: got v%b %h z%b want v1 0 z1", i, d_rsp1_valid, d_rsp1_r, d_rsp1_z); end
    end
    rsp1_ready = 1'b1;
    #1;
    n_cmp++; if (d_req1_ready !== 1'b0) begin n_bad++; $display("FAIL no_bypass: got %b want 0", d_req1_ready); end
    @(negedge clk);
    rsp1_ready = 1'b0;
    n_cmp++; if (d_rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL hold_consume: got %b want 0", d_rsp1_valid); end
    #1;
    n_cmp++; if (d_req1_ready !== 1'b1) begin n_bad++; $display("FAIL regrant: got %b want 1", d_req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({d_rsp1_valid, d_rsp1_r, d_rsp1_z} !== {1'b1, 32'd3, 1'b0}) begin n_bad++; $display("FAIL second_result: got v%b %h z%b want v1 3 z0", d_rsp1_valid, d_rsp1_r, d_rsp1_z); end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
  endtask

  task automatic test_alternate();
    int exp_g[4] = '{0, 1, 0, 1};
    int gi = 0;
    int pi = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_aluc = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_aluc = 4'b0100;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (d_req0_ready || d_req1_ready) begin
        n_cmp++; if ((gi > 3) || (d_req0_ready && d_req1_ready) || (int'(d_req1_ready) != exp_g[gi & 3])) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b%b want id %0d", gi, d_req0_ready, d_req1_ready, exp_g[gi & 3]); end
        gi++;
      end
      if (p_req0_ready || p_req1_ready) begin
        n_cmp++; if ((pi > 3) || (p_req0_ready && p_req1_ready) || (int'(p_req1_ready) != exp_g[pi & 3])) begin n_bad++; $display("FAIL prio_grant[%0d]: got %b%b want id %0d", pi, p_req0_ready, p_req1_ready, exp_g[pi & 3]); end
        pi++;
      end
      if (d_rsp0_valid) begin
        n_cmp++; if (d_rsp0_r !== 32'd3) begin n_bad++; $display("FAIL alt_rsp0: got %h want 3", d_rsp0_r); end
      end
      if (d_rsp1_valid) begin
        n_cmp++; if (d_rsp1_r !== 32'd7) begin n_bad++; $display("FAIL alt_rsp1: got %h want 7", d_rsp1_r); end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++; if ((gi != 4) || (pi != 4)) begin n_bad++; $display("FAIL alt_count: got %0d/%0d want 4/4", gi, pi); end
    repeat (3) @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_tie();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_aluc = 4'b0000;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    n_cmp++; if ({d_req0_ready, p_req0_ready} !== 2'b11) begin n_bad++; $display("FAIL solo_grant: got %b want 11", {d_req0_ready, p_req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++; if ({d_req0_ready, d_req1_ready} !== 2'b01) begin n_bad++; $display("FAIL rr_tie: got %b want 01", {d_req0_ready, d_req1_ready}); end
    n_cmp++; if ({p_req0_ready, p_req1_ready} !== 2'b10) begin n_bad++; $display("FAIL prio_tie: got %b want 10", {p_req0_ready, p_req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_route();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'h8000_0000; req0_aluc = 4'b1111;
    #1;
    n_cmp++; if (d_req0_ready !== 1'b1) begin n_bad++; $display("FAIL sra_ready: got %b want 1", d_req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({d_rsp0_valid, d_rsp0_r} !== {1'b1, 32'hF800_0000}) begin n_bad++; $display("FAIL sra_result: got v%b %h want v1 f8000000", d_rsp0_valid, d_rsp0_r); end
    n_cmp++; if (d_rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL sra_other: got %b want 0", d_rsp1_valid); end
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'h0000_1234; req1_aluc = 4'b0110;
    #1;
    n_cmp++; if ({d_req0_ready, d_req1_ready} !== 2'b01) begin n_bad++; $display("FAIL lui_ready: got %b want 01", {d_req0_ready, d_req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({d_rsp1_valid, d_rsp1_r} !== {1'b1, 32'h1234_0000}) begin n_bad++; $display("FAIL lui_result: got v%b %h want v1 12340000", d_rsp1_valid, d_rsp1_r); end
    n_cmp++; if ({d_rsp0_valid, d_rsp0_r} !== {1'b1, 32'hF800_0000}) begin n_bad++; $display("FAIL lui_disturb: got v%b %h want v1 f8000000", d_rsp0_valid, d_rsp0_r); end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_aluc = 4'b0100;
    #1;
    n_cmp++; if (d_req1_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", d_req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    n_cmp++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", d_busy); end
    #2 clrn = 1'b0;
    #1;
    n_cmp++; if ({d_busy, d_rsp1_valid, d_rsp0_valid} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_flags: got %b want 000", {d_busy, d_rsp1_valid, d_rsp0_valid}); end
    n_cmp++; if ({d_alu_a, d_alu_aluc, d_rsp0_r} !== {32'h0, 4'h0, 32'h0}) begin n_bad++; $display("FAIL mid_rst_regs: got %h %h %h want 0 0 0", d_alu_a, d_alu_aluc, d_rsp0_r); end
    @(negedge clk);
    n_cmp++; if (d_rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL mid_dropped: got %b want 0", d_rsp1_valid); end
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_aluc = 4'b0000;
    req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd3; req1_aluc = 4'b0001;
    #1;
    n_cmp++; if ({d_req0_ready, d_req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_no_grant: got %b want 00", {d_req0_ready, d_req1_ready}); end
    @(negedge clk);
    clrn = 1'b1;
    #1;
    n_cmp++; if ({d_req0_ready, d_req1_ready, p_req0_ready, p_req1_ready} !== 4'b1010) begin n_bad++; $display("FAIL post_rst_tie: got %b want 1010", {d_req0_ready, d_req1_ready, p_req0_ready, p_req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({d_rsp0_valid, d_rsp0_r, d_rsp1_valid} !== {1'b1, 32'd2, 1'b0}) begin n_bad++; $display("FAIL post_rst_result: got v%b %h v1=%b want v1 2 v1=0", d_rsp0_valid, d_rsp0_r, d_rsp1_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_hold();
    test_alternate();
    test_tie();
    test_route();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
